// File: rtl/simon_autoplayer_if.sv
// Pin-level bundle between the Simon game core and the autoplayer.
// The game side drives en/led; the player drives the buttons and status flags.
interface simon_autoplayer_if #(
  parameter int unsigned MAX_LEN = 32
) ();
  localparam int unsigned LenW = $clog2(MAX_LEN + 1);

  logic            en;
  logic [3:0]      led;
  logic [3:0]      btn;
  logic            busy;
  logic [LenW-1:0] len;
  logic            round_done;
  logic            overflow;
  logic            err;

  modport master (
    output en, led,
    input  btn, busy, len, round_done, overflow, err
  );

  modport slave (
    input  en, led,
    output btn, busy, len, round_done, overflow, err
  );
endinterface

// File: rtl/simon_autoplayer.sv
// Simon autoplayer: records the colour sequence the game plays on its LEDs, then replays it
// on the buttons once the LEDs have stayed dark long enough.
module simon_autoplayer #(
  parameter int unsigned MAX_LEN      = 32,
  parameter int unsigned IDLE_CYCLES  = 1000,
  parameter int unsigned PRESS_CYCLES = 200,
  parameter int unsigned GAP_CYCLES   = 200
) (
  input logic               clk,
  input logic               rst,
  simon_autoplayer_if.slave io
);

  localparam int unsigned LenW   = $clog2(MAX_LEN + 1);
  localparam int unsigned IdxW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TmrMax = (IDLE_CYCLES > PRESS_CYCLES) ?
                                   ((IDLE_CYCLES > GAP_CYCLES) ? IDLE_CYCLES : GAP_CYCLES) :
                                   ((PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES);
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);

  // The first dark sample is taken in LISTEN_ON, so LISTEN_OFF only needs IDLE_CYCLES-1 more.
  localparam int unsigned IdleLastI  = (IDLE_CYCLES >= 2) ? IDLE_CYCLES - 2 : 0;
  localparam int unsigned PressLastI = (PRESS_CYCLES >= 1) ? PRESS_CYCLES - 1 : 0;
  localparam int unsigned GapLastI   = (GAP_CYCLES >= 1) ? GAP_CYCLES - 1 : 0;

  localparam logic [TmrW-1:0] IdleLast  = TmrW'(IdleLastI);
  localparam logic [TmrW-1:0] PressLast = TmrW'(PressLastI);
  localparam logic [TmrW-1:0] GapLast   = TmrW'(GapLastI);
  localparam logic [LenW-1:0] LenMax    = LenW'(MAX_LEN);

  typedef enum logic [2:0] {
    StIdle,
    StListenOn,
    StListenOff,
    StPress,
    StGap,
    StHalt
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      led_q;
  logic [LenW-1:0] len_q, len_d;
  logic [LenW-1:0] idx_q, idx_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic [3:0]      btn_q, btn_d;
  logic            busy_q, busy_d;
  logic            round_done_q, round_done_d;
  logic            overflow_q, overflow_d;
  logic            err_q, err_d;

  logic [1:0]      mem_q [MAX_LEN];
  logic            mem_we;
  logic [IdxW-1:0] mem_waddr;

  logic            led_onehot;
  logic            led_bad;
  logic            step;
  logic [1:0]      led_code;

  function automatic logic [3:0] code2onehot(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

  always_comb begin
    led_onehot = (io.led != 4'b0000) && ((io.led & (io.led - 4'b0001)) == 4'b0000);
    led_bad    = (io.led != 4'b0000) && !led_onehot;
    step       = (led_q == 4'b0000) && led_onehot;
  end

  always_comb begin
    led_code = 2'd0;
    if (io.led[1]) led_code = 2'd1;
    if (io.led[2]) led_code = 2'd2;
    if (io.led[3]) led_code = 2'd3;
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    round_done_d = 1'b0;
    overflow_d   = overflow_q;
    err_d        = err_q;
    mem_we       = 1'b0;
    mem_waddr    = len_q[IdxW-1:0];

    if (!io.en) begin
      state_d = StIdle;
      len_d   = '0;
      idx_d   = '0;
      timer_d = '0;
    end else begin
      if (led_bad) err_d = 1'b1;

      unique case (state_q)
        StIdle: begin
          if (step) begin
            mem_we    = 1'b1;
            mem_waddr = '0;
            len_d     = LenW'(1);
            state_d   = StListenOn;
          end
        end

        StListenOn: begin
          if (io.led == 4'b0000) begin
            timer_d = '0;
            state_d = StListenOff;
          end
        end

        StListenOff: begin
          if (step) begin
            if (len_q == LenMax) begin
              overflow_d = 1'b1;
              state_d    = StHalt;
            end else begin
              mem_we  = 1'b1;
              len_d   = len_q + LenW'(1);
              state_d = StListenOn;
            end
          end else if (timer_q >= IdleLast) begin
            idx_d   = '0;
            timer_d = '0;
            state_d = StPress;
          end else begin
            timer_d = timer_q + TmrW'(1);
          end
        end

        StPress: begin
          if (timer_q >= PressLast) begin
            timer_d = '0;
            state_d = StGap;
          end else begin
            timer_d = timer_q + TmrW'(1);
          end
        end

        StGap: begin
          if (timer_q >= GapLast) begin
            timer_d = '0;
            if ((idx_q + LenW'(1)) == len_q) begin
              round_done_d = 1'b1;
              state_d      = StIdle;
            end else begin
              idx_d   = idx_q + LenW'(1);
              state_d = StPress;
            end
          end else begin
            timer_d = timer_q + TmrW'(1);
          end
        end

        StHalt: begin
          state_d = StHalt;
        end

        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are registered from the next state so btn/busy switch on the same edge as state.
  always_comb begin
    btn_d  = 4'b0000;
    busy_d = (state_d == StPress) || (state_d == StGap);
    if (state_d == StPress) btn_d = code2onehot(mem_q[idx_d[IdxW-1:0]]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      led_q        <= 4'b0000;
      len_q        <= '0;
      idx_q        <= '0;
      timer_q      <= '0;
      btn_q        <= 4'b0000;
      busy_q       <= 1'b0;
      round_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      led_q        <= io.led;
      len_q        <= len_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      btn_q        <= btn_d;
      busy_q       <= busy_d;
      round_done_q <= round_done_d;
      overflow_q   <= overflow_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= led_code;
  end

  assign io.btn        = btn_q;
  assign io.busy       = busy_q;
  assign io.len        = len_q;
  assign io.round_done = round_done_q;
  assign io.overflow   = overflow_q;
  assign io.err        = err_q;

endmodule

// File: tb/tb_simon_autoplayer.sv
// Bench for simon_autoplayer: a queue-based model of record/replay checked every cycle,
// directed scenarios with literal expectations, then randomized rounds.
module tb_simon_autoplayer;
  localparam int MAXL  = 4;
  localparam int IDLE  = 8;
  localparam int PRESS = 3;
  localparam int GAP   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  simon_autoplayer_if #(.MAX_LEN(MAXL)) bus ();

  simon_autoplayer #(
    .MAX_LEN     (MAXL),
    .IDLE_CYCLES (IDLE),
    .PRESS_CYCLES(PRESS),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // seq holds the recorded LED values; a replay is a precomputed list of per-cycle outputs.
  logic [3:0] seq[$];
  logic [3:0] pq_btn[$];
  bit         pq_busy[$];
  bit         pq_rd[$];
  int         mode;      // 0 await first colour, 1 await dark, 2 counting dark, 3 halted
  int         m_dark;
  logic [3:0] m_prev;
  logic [3:0] m_btn;
  bit         m_busy, m_rd, m_ovf, m_err;

  function automatic bit is_onehot(input logic [3:0] v);
    return $countones(v) == 1;
  endfunction

  task automatic model_reset();
    seq.delete(); pq_btn.delete(); pq_busy.delete(); pq_rd.delete();
    mode = 0; m_dark = 0; m_prev = 4'b0;
    m_btn = 4'b0; m_busy = 0; m_rd = 0; m_ovf = 0; m_err = 0;
  endtask

  task automatic schedule_replay();
    foreach (seq[i]) begin
      repeat (PRESS) begin pq_btn.push_back(seq[i]); pq_busy.push_back(1); pq_rd.push_back(0); end
      repeat (GAP) begin pq_btn.push_back(4'b0); pq_busy.push_back(1); pq_rd.push_back(0); end
    end
    pq_btn.push_back(4'b0); pq_busy.push_back(0); pq_rd.push_back(1);
  endtask

  task automatic model_step();
    logic [3:0] l;
    bit e, stp;
    l = bus.led;
    e = bus.en;
    stp = (m_prev == 4'b0) && is_onehot(l);
    m_prev = l;
    m_rd = 0;
    if (!e) begin
      seq.delete(); pq_btn.delete(); pq_busy.delete(); pq_rd.delete();
      mode = 0; m_btn = 4'b0; m_busy = 0;
      return;
    end
    if (l != 4'b0 && !is_onehot(l)) m_err = 1;
    if (pq_btn.size() > 0) begin
      m_btn = pq_btn.pop_front(); m_busy = pq_busy.pop_front(); m_rd = pq_rd.pop_front();
      return;
    end
    m_btn = 4'b0; m_busy = 0;
    case (mode)
      0: if (stp) begin seq.delete(); seq.push_back(l); mode = 1; end
      1: if (l == 4'b0) begin mode = 2; m_dark = 1; end
      2: begin
        if (stp) begin
          if (seq.size() == MAXL) begin m_ovf = 1; mode = 3; end
          else begin seq.push_back(l); mode = 1; end
        end else begin
          m_dark++;
          if (m_dark == IDLE) begin
            schedule_replay();
            m_btn = pq_btn.pop_front(); m_busy = pq_busy.pop_front(); m_rd = pq_rd.pop_front();
            mode = 0;
          end
        end
      end
      default: ;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("btn",        int'(bus.btn),        int'(m_btn));
      chk("busy",       int'(bus.busy),       int'(m_busy));
      chk("round_done", int'(bus.round_done), int'(m_rd));
      chk("len",        int'(bus.len),        seq.size());
      chk("overflow",   int'(bus.overflow),   int'(m_ovf));
      chk("err",        int'(bus.err),        int'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] c, input int on, input int off);
    bus.led = c;
    tick(on);
    bus.led = 4'b0;
    tick(off);
  endtask

  function automatic logic [3:0] rand_colour();
    logic [3:0] v;
    v = 4'b0001 << $urandom_range(0, 3);
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_hi, hi_cnt, rd_cnt, first_rd;
    logic [3:0] hi_val, last_btn;
    logic [3:0] runs[$];
    bit found;

    bus.en  = 1'b1;
    bus.led = 4'b0;
    tick(2);
    rst = 1'b0;
    chk("reset btn", int'(bus.btn), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset len", int'(bus.len), 0);
    chk("reset overflow", int'(bus.overflow), 0);
    chk("reset err", int'(bus.err), 0);
    tick(2);

    // Basic round
    pulse(4'b0001, 2, 0);
    first_hi = -1; hi_cnt = 0; rd_cnt = 0; first_rd = -1; hi_val = 4'b0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (bus.btn != 4'b0) begin
        if (first_hi < 0) first_hi = i;
        hi_cnt++; hi_val = bus.btn;
      end
      if (bus.round_done) begin
        if (first_rd < 0) first_rd = i;
        rd_cnt++;
      end
    end
    chk("basic first press cycle", first_hi, 8);
    chk("basic press width", hi_cnt, 3);
    chk("basic press value", int'(hi_val), 1);
    chk("basic round_done cycle", first_rd, 13);
    chk("basic round_done count", rd_cnt, 1);
    chk("basic len", int'(bus.len), 1);

    // Three-step round with LED echo during replay
    pulse(4'b0010, 2, 3);
    pulse(4'b1000, 2, 3);
    pulse(4'b0100, 2, 0);
    last_btn = 4'b0; rd_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (bus.btn != 4'b0 && bus.btn != last_btn) runs.push_back(bus.btn);
      last_btn = bus.btn;
      if (bus.round_done) rd_cnt++;
      bus.led = bus.btn;
    end
    bus.led = 4'b0;
    chk("three runs", runs.size(), 3);
    if (runs.size() == 3) begin
      chk("three run0", int'(runs[0]), 2);
      chk("three run1", int'(runs[1]), 8);
      chk("three run2", int'(runs[2]), 4);
    end
    chk("three round_done", rd_cnt, 1);
    chk("three len after echo", int'(bus.len), 3);

    // Bad input: non-one-hot, then a change without a dark cycle
    pulse(4'b0011, 1, 2);
    chk("bad err", int'(bus.err), 1);
    chk("bad len unchanged", int'(bus.len), 3);
    bus.led = 4'b0001; tick(1);
    bus.led = 4'b0010; tick(1);
    bus.led = 4'b0; tick(3);
    chk("no-dark change len", int'(bus.len), 1);
    tick(25);

    // Idle boundary: 7 dark cycles still recorded, 8 are not
    pulse(4'b0001, 1, 7);
    pulse(4'b0100, 1, 2);
    chk("boundary 7 len", int'(bus.len), 2);
    tick(30);
    pulse(4'b0001, 1, 8);
    chk("boundary 8 replay started", int'(bus.btn), 1);
    pulse(4'b0010, 1, 2);
    chk("boundary 8 len", int'(bus.len), 1);
    tick(20);

    // Overflow into HALT
    for (int i = 0; i < 5; i++) pulse(rand_colour(), 1, 2);
    chk("overflow set", int'(bus.overflow), 1);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.btn != 4'b0) found = 1;
    end
    chk("halt btn quiet", int'(found), 0);
    bus.en = 1'b0; tick(1);
    chk("en low len", int'(bus.len), 0);
    bus.en = 1'b1; tick(1);
    chk("overflow sticky", int'(bus.overflow), 1);

    // Asynchronous reset during PRESS
    pulse(4'b0100, 1, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (bus.btn != 4'b0) found = 1;
    end
    chk("reach press before rst", int'(found), 1);
    #1 rst = 1'b1;
    #1;
    chk("rst btn async", int'(bus.btn), 0);
    chk("rst busy", int'(bus.busy), 0);
    chk("rst overflow", int'(bus.overflow), 0);
    chk("rst err", int'(bus.err), 0);
    chk("rst len", int'(bus.len), 0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // en low during GAP
    pulse(4'b1000, 1, 0);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(1);
      if (bus.busy && bus.btn == 4'b0) found = 1;
    end
    chk("reach gap", int'(found), 1);
    bus.en = 1'b0; tick(1);
    chk("gap en-low len", int'(bus.len), 0);
    chk("gap en-low busy", int'(bus.busy), 0);
    chk("gap en-low btn", int'(bus.btn), 0);
    bus.en = 1'b1; tick(2);

    // Randomized rounds with echo noise and occasional enable drops
    for (int r = 0; r < 40; r++) begin
      int n;
      n = $urandom_range(1, MAXL + 1);
      for (int s = 0; s < n; s++) pulse(rand_colour(), $urandom_range(1, 3), $urandom_range(1, 9));
      for (int c = 0; c < n * (PRESS + GAP) + IDLE + 4; c++) begin
        int p;
        p = $urandom_range(0, 99);
        if (p < 20) bus.led = rand_colour();
        else if (p < 22) bus.led = 4'($urandom_range(0, 15));
        else bus.led = 4'b0;
        bus.en = ($urandom_range(0, 199) != 0);
        tick(1);
      end
      bus.led = 4'b0;
      bus.en  = 1'b1;
      tick(IDLE + 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
